subtractor_32bits_seq: RTL and testbench
========================================

// Module: subtractor_32bits_seq
// PURPOSE
//   Multi-cycle 32-bit subtractor. Computes out = in1 - in2 - bin, one SLICE_W-bit
//   slice per clock, least-significant slice first, with a registered borrow chain.
//   Inverse companion of the 32-bit adder datapath; used by the ALU where area
//   matters more than latency. Bit 0 is the MSB and bit 31 is the LSB ([0:31] ordering).
// PARAMETERS
//   SLICE_W  8  bits per step; legal values 1,2,4,8,16,32; NSLICE = 32/SLICE_W
// PORTS
//   clk      in   1   clock, rising edge
//   rst_n    in   1   asynchronous active-low reset
//   start    in   1   request; accepted only when ready=1
//   in1      in   32  minuend [0:31], sampled when start is accepted
//   in2      in   32  subtrahend [0:31], sampled when start is accepted
//   bin      in   1   borrow in, sampled when start is accepted
//   ready    out  1   1 = IDLE, can accept start
//   out      out  32  difference [0:31]; valid while done=1, held until next accept
//   bout     out  1   borrow out: 1 iff unsigned in1 < in2 + bin
//   ovf      out  1   signed overflow of in1 - in2 - bin
//   done     out  1   one-cycle pulse, result valid
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, ready=1, out=0, bout=0, ovf=0, done=0,
//     slice counter=0, internal borrow=0. Takes effect immediately, even mid-operation;
//     the in-flight result is discarded and no done pulse is issued.
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   IDLE: ready=1. On edge with start=1:
//     - latch in1, in2, bin
//     - borrow register = bin, counter = 0, clear out
//     - go to RUN
//   RUN (NSLICE cycles), ready=0. At edge with counter=k:
//     - slice = bits [32-(k+1)*SLICE_W : 31-k*SLICE_W]
//     - {b, d} = a_slice - b_slice - borrow
//     - write d to out at that slice, borrow = b, counter = k+1
//     - after slice NSLICE-1, go to DONE
//   DONE (1 cycle): done=1, ready=0.
//     - bout = final borrow
//     - ovf = (in1[0] != in2[0]) & (out[0] != in1[0]); the bin bit is included in out
//     - next edge: IDLE
//   Latency: start accepted at edge T0 -> done high in cycle after edge T(NSLICE+1).
//     Default: 5 cycles from accept to done.
//   start while ready=0 is ignored; it is not queued.
//   out, bout and ovf hold their values in IDLE until the next start is accepted.
//   Back-to-back: start held high in the DONE->IDLE cycle is accepted on the next edge.
//   Inputs may change freely after accept; only the latched copy is used.
//   Arithmetic is modulo 2^32. Equivalent form: in1 + ~in2 + ~bin, with bout = ~carry.
// TESTING
//   1 in1=5, in2=3, bin=0 -> out=0x00000002, bout=0, ovf=0, done pulse 5 cycles
//     after accept.
//   2 in1=0, in2=1, bin=0 -> out=0xFFFFFFFF, bout=1, ovf=0.
//     in1=0, in2=0, bin=1 -> same result.
//   3 in1=0x80000000, in2=1 -> out=0x7FFFFFFF, bout=0, ovf=1.
//     in1=0x7FFFFFFF, in2=0xFFFFFFFF -> out=0x80000000, bout=1, ovf=1.
//   4 Borrow ripple across all slices: in1=0x01000000, in2=1 -> out=0x00FFFFFF.
//     Repeat for SLICE_W=1, 4, 32 against a reference model.
//   5 Pulse start again in cycle 2 of RUN -> ignored; exactly one done, first result intact.
//     Start held high continuously -> accepts every 6 cycles.
//   6 Assert rst_n=0 in cycle 3 of RUN -> all outputs zero immediately, ready=1, no done.
//     A new start after reset release gives a correct result.

Source files
------------

// File: rtl/subtractor_32bits_seq.sv
// Multi-cycle 32-bit subtractor: one SLICE_W-bit slice per clock, LSB slice first,
// with a registered borrow chain. Vectors use [0:31] ordering (bit 0 is the MSB).
module subtractor_32bits_seq #(
    parameter int SLICE_W = 8  // legal: 1, 2, 4, 8, 16, 32
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [0:31] in1,
    input  logic [0:31] in2,
    input  logic        bin,
    output logic        ready,
    output logic [0:31] out,
    output logic        bout,
    output logic        ovf,
    output logic        done,
    output logic [1:0]  state_dbg
);

    localparam int NSLICE = 32 / SLICE_W;
    localparam int CW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST = CW'(NSLICE - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Handshake: start is taken on a rising edge only while ready=1 (IDLE);
    // done is a one-cycle pulse and out/bout/ovf hold until the next accept.
    state_t          state;
    logic [0:31]     a_q;
    logic [0:31]     b_q;
    logic            borrow;
    logic [CW-1:0]   cnt;
    logic [4:0]      base;
    logic [SLICE_W:0] diff;

    // Slice k covers ascending bits [base : base+SLICE_W-1], counted from the LSB end.
    always_comb begin
        base = 5'(32 - (int'(cnt) + 1) * SLICE_W);
        diff = {1'b0, a_q[base +: SLICE_W]}
             - {1'b0, b_q[base +: SLICE_W]}
             - {{SLICE_W{1'b0}}, borrow};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            a_q    <= '0;
            b_q    <= '0;
            borrow <= 1'b0;
            cnt    <= '0;
            out    <= '0;
            bout   <= 1'b0;
            ovf    <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q    <= in1;
                        b_q    <= in2;
                        borrow <= bin;
                        cnt    <= '0;
                        out    <= '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    out[base +: SLICE_W] <= diff[SLICE_W-1:0];
                    borrow <= diff[SLICE_W];
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) state <= DONE;
                end
                DONE: begin
                    done  <= 1'b1;
                    bout  <= borrow;
                    ovf   <= (a_q[0] != b_q[0]) & (out[0] != a_q[0]);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign ready     = (state == IDLE);
    assign state_dbg = state;

endmodule

// File: tb/tb_subtractor_32bits_seq.sv
// Bench for subtractor_32bits_seq: four slice widths side by side, checked against
// a plain-arithmetic model of in1 - in2 - bin with signed overflow.
module tb_subtractor_32bits_seq;

    localparam int WID [4] = '{8, 1, 4, 32};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  start_v = 4'h0;
    logic [0:31] in1 = '0;
    logic [0:31] in2 = '0;
    logic        bin = 1'b0;
    logic        ready_v [4];
    logic [0:31] out_v   [4];
    logic        bout_v  [4];
    logic        ovf_v   [4];
    logic        done_v  [4];
    logic [1:0]  st_v    [4];

    int checks = 0;
    int failures = 0;
    logic [33:0] exp_q[$];

    subtractor_32bits_seq #(.SLICE_W(8)) u0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .in1(in1), .in2(in2), .bin(bin),
        .ready(ready_v[0]), .out(out_v[0]), .bout(bout_v[0]), .ovf(ovf_v[0]),
        .done(done_v[0]), .state_dbg(st_v[0]));
    subtractor_32bits_seq #(.SLICE_W(1)) u1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .in1(in1), .in2(in2), .bin(bin),
        .ready(ready_v[1]), .out(out_v[1]), .bout(bout_v[1]), .ovf(ovf_v[1]),
        .done(done_v[1]), .state_dbg(st_v[1]));
    subtractor_32bits_seq #(.SLICE_W(4)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .in1(in1), .in2(in2), .bin(bin),
        .ready(ready_v[2]), .out(out_v[2]), .bout(bout_v[2]), .ovf(ovf_v[2]),
        .done(done_v[2]), .state_dbg(st_v[2]));
    subtractor_32bits_seq #(.SLICE_W(32)) u3 (
        .clk(clk), .rst_n(rst_n), .start(start_v[3]), .in1(in1), .in2(in2), .bin(bin),
        .ready(ready_v[3]), .out(out_v[3]), .bout(bout_v[3]), .ovf(ovf_v[3]),
        .done(done_v[3]), .state_dbg(st_v[3]));

    // Clock
    initial forever #5 clk = ~clk;

    // Reference: {bout, ovf, out} from unsigned and signed integer arithmetic.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic bi);
        logic [32:0] r;
        longint      s;
        logic        v;
        r = {1'b0, a} - {1'b0, b} - {32'd0, bi};
        s = longint'($signed(a)) - longint'($signed(b)) - longint'(bi);
        v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        return {r[32], v, r[31:0]};
    endfunction

    task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Watch the masked instances for ncyc edges; each must pulse done exactly once
    // with the result at the head of exp_q and latency NSLICE+1 from accept.
    task automatic collect(input logic [3:0] mask, input int c0, input int ncyc);
        int seen [4] = '{0, 0, 0, 0};
        for (int c = c0; c <= ncyc; c++) begin
            @(posedge clk); #1;
            for (int i = 0; i < 4; i++) begin
                if (mask[i] && done_v[i] === 1'b1) begin
                    seen[i]++;
                    if (seen[i] == 1) begin
                        check($sformatf("latency_w%0d", WID[i]), 34'(c), 34'(32 / WID[i] + 1));
                        check($sformatf("result_w%0d", WID[i]),
                              {bout_v[i], ovf_v[i], out_v[i]}, exp_q[0]);
                    end
                end
            end
        end
        for (int i = 0; i < 4; i++)
            if (mask[i]) check($sformatf("done_count_w%0d", WID[i]), 34'(seen[i]), 34'd1);
        void'(exp_q.pop_front());
    endtask

    task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic bi,
                         input logic [3:0] mask);
        @(negedge clk);
        in1 = a; in2 = b; bin = bi; start_v = mask;
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic bi,
                          input logic [3:0] mask);
        exp_q.push_back(model(a, b, bi));
        drive(a, b, bi, mask);
        for (int i = 0; i < 4; i++)
            if (mask[i]) check($sformatf("ready_idle_w%0d", WID[i]), 34'(ready_v[i]), 34'd1);
        @(posedge clk); #1;
        start_v = 4'h0;
        in1 = $urandom; in2 = $urandom; bin = 1'($urandom);
        collect(mask, 1, 40);
    endtask

    initial begin
        int times [$];
        logic [31:0] a, b;

        // Reset state
        #1;
        for (int i = 0; i < 4; i++) begin
            check("rst_ready", 34'(ready_v[i]), 34'd1);
            check("rst_out", 34'(out_v[i]), 34'd0);
            check("rst_flags", {31'd0, bout_v[i], ovf_v[i], done_v[i]}, 34'd0);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Directed corners on every slice width
        run_op(32'd5, 32'd3, 1'b0, 4'hF);
        run_op(32'd0, 32'd1, 1'b0, 4'hF);
        run_op(32'd0, 32'd0, 1'b1, 4'hF);
        run_op(32'h80000000, 32'd1, 1'b0, 4'hF);
        run_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 4'hF);
        run_op(32'h01000000, 32'd1, 1'b0, 4'hF);
        run_op(32'h80000000, 32'd0, 1'b1, 4'hF);

        // Randomized operands with biased corner classes
        for (int n = 0; n < 20; n++) begin
            case ($urandom_range(0, 3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom_range(0, 255); b = $urandom | 32'h80000000; end
                2: begin a = $urandom; b = a; end
                default: begin
                    a = ($urandom_range(0, 1) != 0) ? 32'h80000000 : 32'h7FFFFFFF;
                    b = ($urandom_range(0, 1) != 0) ? 32'hFFFFFFFF : 32'h00000001;
                end
            endcase
            run_op(a, b, 1'($urandom), 4'hF);
        end

        // Start pulsed again during RUN is ignored
        exp_q.push_back(model(32'h00001234, 32'h00000235, 1'b0));
        drive(32'h00001234, 32'h00000235, 1'b0, 4'h1);
        @(posedge clk); #1 start_v = 4'h0;
        @(posedge clk);
        drive(32'hDEADBEEF, 32'h11111111, 1'b1, 4'h1);
        @(posedge clk); #1 start_v = 4'h0;
        collect(4'h1, 3, 30);

        // Start held high: accepts every 6 cycles
        exp_q.push_back(model(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0));
        drive(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 4'h1);
        for (int c = 1; c <= 20; c++) begin
            @(posedge clk); #1;
            if (done_v[0] === 1'b1) begin
                times.push_back(c);
                check("held_result", {bout_v[0], ovf_v[0], out_v[0]}, exp_q[0]);
            end
        end
        start_v = 4'h0;
        check("held_done_count", 34'(times.size()), 34'd3);
        if (times.size() == 3) begin
            check("held_first", 34'(times[0]), 34'd6);
            check("held_gap1", 34'(times[1] - times[0]), 34'd6);
            check("held_gap2", 34'(times[2] - times[1]), 34'd6);
        end
        void'(exp_q.pop_front());
        repeat (12) @(posedge clk);

        // Asynchronous reset in the middle of RUN
        drive(32'hFFFFFFFF, 32'd0, 1'b0, 4'h1);
        @(posedge clk); #1 start_v = 4'h0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_out", 34'(out_v[0]), 34'd0);
        check("midrst_flags", {31'd0, bout_v[0], ovf_v[0], done_v[0]}, 34'd0);
        check("midrst_ready", 34'(ready_v[0]), 34'd1);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            check("no_done_after_rst", 34'(done_v[0]), 34'd0);
        end
        run_op(32'h12345678, 32'h9ABCDEF0, 1'b1, 4'hF);

        // Final report
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
